instruction_fetch_unit: RTL and testbench

Fetch stage sitting directly upstream of InstructionMemory in the multi-cycle processor. It owns the fetch PC, drives `inst_address`, and waits a fixed number of cycles for `read_data`. It then latches the word into the instruction register (IR) and presents it to the control/decode FSM with a valid/ack handshake. It also supports PC redirection for branches and jumps.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_pc_reg.sv | 26 ++
 rtl/instruction_fetch_unit.sv | 132 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 32;
  localparam int LAT_CNT_W   = 4;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, WAIT, VALID} state_e;
endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch address register: load, wrapping increment, async reset to RESET_PC.
module fetch_pc_reg #(
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              inc,
  output logic [ADDR_W-1:0] fetch_addr
);
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load)     addr_d = load_value;
    else if (inc) addr_d = addr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) addr_q <= RESET_PC;
    else        addr_q <= addr_d;

  assign fetch_addr = addr_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns fetch PC, waits MEM_LATENCY cycles, latches IR, valid/ack to decode.
// Optional halt detection on HALT_WORD when FETCH_HALT_DETECT_EN is defined.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                INSTR_W     = INSTR_W_DEF,
  parameter int                MEM_LATENCY = 1,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_load_value,
  output logic [ADDR_W-1:0]  inst_address,
  input  logic [INSTR_W-1:0] read_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ack,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus1,
  output logic               busy
`ifdef FETCH_HALT_DETECT_EN
  ,
  output logic               halted
`endif
);
  localparam logic [LAT_CNT_W-1:0] LAT = LAT_CNT_W'(MEM_LATENCY);

  state_e               state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic                 valid_q, valid_d;
  logic                 fa_load, fa_inc;
  logic                 cap, halt_cap, halt_blk;

  fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (fa_load),
    .load_value (pc_load_value),
    .inc        (fa_inc),
    .fetch_addr (inst_address)
  );

  // Capture edge: last wait cycle, not aborted by a redirect.
  assign cap = (state_q == WAIT) && !pc_load && (cnt_q == LAT_CNT_W'(1));

`ifdef FETCH_HALT_DETECT_EN
  logic halted_q, halted_d;
  assign halt_cap = (read_data == INSTR_W'(HALT_WORD));
  assign halt_blk = halted_q;
  assign halted_d = !pc_load && (halted_q || (cap && halt_cap));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  assign halted = halted_q;
`else
  assign halt_cap = 1'b0;
  assign halt_blk = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    fa_load = 1'b0;
    fa_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pc_load) fa_load = 1'b1;
        else if (fetch_req && !halt_blk) begin
          state_d = WAIT;
          cnt_d   = LAT;
        end
      end
      WAIT: begin
        if (pc_load) begin
          fa_load = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cap) begin
          instr_d = read_data;
          pc_d    = inst_address;
          valid_d = 1'b1;
          fa_inc  = !halt_cap;
          cnt_d   = '0;
          state_d = VALID;
        end else cnt_d = cnt_q - 1'b1;
      end
      VALID: begin
        fa_load = pc_load;
        if (instr_ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
          if (!pc_load && fetch_req && !halt_blk) begin
            state_d = WAIT;
            cnt_d   = LAT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == WAIT);
    instr       = instr_q;
    instr_valid = valid_q;
    pc          = pc_q;
    pc_plus1    = pc_q + 1'b1;
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench: instance A (MEM_LATENCY=1) and B (MEM_LATENCY=3) with scoreboard monitors.
module tb_instruction_fetch_unit;
  typedef struct {
    logic [31:0] instr;
    logic [15:0] pc;
    logic [15:0] pcp1;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  logic a_seen = 1'b0, b_seen = 1'b0;

  logic        a_rst_n, a_fetch_req, a_pc_load, a_ack, a_valid, a_busy;
  logic [15:0] a_plv, a_addr, a_pc, a_pcp1;
  logic [31:0] a_rd, a_instr;
  logic        b_rst_n, b_fetch_req, b_pc_load, b_ack, b_valid, b_busy;
  logic [15:0] b_plv, b_addr, b_pc, b_pcp1;
  logic [31:0] b_rd, b_instr;
`ifdef FETCH_HALT_DETECT_EN
  logic a_halted, b_halted;
`endif

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 32'h2000_0004;
      16'h0001: mem_word = 32'h1111_1111;
      16'h0002: mem_word = 32'hFFFF_FFFF;
      default:  mem_word = {16'hC0DE, a};
    endcase
  endfunction

  assign a_rd = mem_word(a_addr);
  assign b_rd = mem_word(b_addr);

  instruction_fetch_unit #(.MEM_LATENCY(1)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .fetch_req(a_fetch_req), .pc_load(a_pc_load),
    .pc_load_value(a_plv), .inst_address(a_addr), .read_data(a_rd), .instr(a_instr),
    .instr_valid(a_valid), .instr_ack(a_ack), .pc(a_pc), .pc_plus1(a_pcp1), .busy(a_busy)
`ifdef FETCH_HALT_DETECT_EN
    , .halted(a_halted)
`endif
  );

  instruction_fetch_unit #(.MEM_LATENCY(3)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .fetch_req(b_fetch_req), .pc_load(b_pc_load),
    .pc_load_value(b_plv), .inst_address(b_addr), .read_data(b_rd), .instr(b_instr),
    .instr_valid(b_valid), .instr_ack(b_ack), .pc(b_pc), .pc_plus1(b_pcp1), .busy(b_busy)
`ifdef FETCH_HALT_DETECT_EN
    , .halted(b_halted)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic stp();
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare each newly presented instruction against the scoreboard.
  always @(negedge clk) begin
    if (a_valid && !a_seen) begin
      a_seen = 1'b1;
      if (qa.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL a_unexpected: got instr %h want none", a_instr);
      end else begin
        ea = qa.pop_front();
        chk("a_instr", a_instr, ea.instr);
        chk("a_pc", {16'h0, a_pc}, {16'h0, ea.pc});
        chk("a_pc_plus1", {16'h0, a_pcp1}, {16'h0, ea.pcp1});
      end
    end else if (!a_valid) a_seen = 1'b0;
  end

  always @(negedge clk) begin
    if (b_valid && !b_seen) begin
      b_seen = 1'b1;
      if (qb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL b_unexpected: got instr %h want none", b_instr);
      end else begin
        eb = qb.pop_front();
        chk("b_instr", b_instr, eb.instr);
        chk("b_pc", {16'h0, b_pc}, {16'h0, eb.pc});
        chk("b_pc_plus1", {16'h0, b_pcp1}, {16'h0, eb.pcp1});
      end
    end else if (!b_valid) b_seen = 1'b0;
  end

  initial begin
    a_rst_n = 0; a_fetch_req = 0; a_pc_load = 0; a_ack = 0; a_plv = '0;
    b_rst_n = 0; b_fetch_req = 0; b_pc_load = 0; b_ack = 0; b_plv = '0;
    #1;
    chk("rst_instr", a_instr, 32'h0);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_pc", a_pc, 16'h0);
    chk("rst_pc_plus1", a_pcp1, 16'h1);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_addr", a_addr, 16'h0);
    repeat (2) stp();
    a_rst_n = 1; b_rst_n = 1;
    stp();

    // A: first fetch, latency 1
    qa.push_back('{32'h2000_0004, 16'h0000, 16'h0001});
    a_fetch_req = 1; stp(); a_fetch_req = 0;
    chk("a_busy_wait", a_busy, 1'b1);
    chk("a_addr_wait", a_addr, 16'h0);
    stp();
    chk("a_valid_first", a_valid, 1'b1);
    chk("a_addr_inc", a_addr, 16'h1);
    chk("a_busy_done", a_busy, 1'b0);

    // A: back-to-back via ack + fetch_req
    qa.push_back('{32'h1111_1111, 16'h0001, 16'h0002});
    a_ack = 1; a_fetch_req = 1; stp(); a_ack = 0; a_fetch_req = 0;
    chk("a_b2b_busy", a_busy, 1'b1);
    chk("a_b2b_valid_low", a_valid, 1'b0);
    stp();
    chk("a_b2b_busy_1cyc", a_busy, 1'b0);
    chk("a_b2b_valid", a_valid, 1'b1);
    chk("a_b2b_addr", a_addr, 16'h2);

    // A: fetch_req in VALID without ack is ignored
    a_fetch_req = 1; stp(); a_fetch_req = 0;
    chk("a_valid_ign_busy", a_busy, 1'b0);
    chk("a_valid_ign_valid", a_valid, 1'b1);

    // A: redirect mid-WAIT
    a_ack = 1; stp(); a_ack = 0;
    chk("a_ack_valid", a_valid, 1'b0);
    a_fetch_req = 1; stp(); a_fetch_req = 0;
    chk("a_redir_busy", a_busy, 1'b1);
    a_pc_load = 1; a_plv = 16'h0040; stp(); a_pc_load = 0;
    chk("a_redir_idle", a_busy, 1'b0);
    chk("a_redir_addr", a_addr, 16'h0040);
    chk("a_redir_ir", a_instr, 32'h1111_1111);
    chk("a_redir_pc", a_pc, 16'h1);
    chk("a_redir_valid", a_valid, 1'b0);
    qa.push_back('{32'hC0DE_0040, 16'h0040, 16'h0041});
    a_fetch_req = 1; stp(); a_fetch_req = 0; stp();
    chk("a_redir_fetch_addr", a_addr, 16'h0041);

    // A: wrap at 16'hFFFF, ack + pc_load
    a_ack = 1; a_pc_load = 1; a_plv = 16'hFFFF; stp(); a_ack = 0; a_pc_load = 0;
    chk("a_ackld_valid", a_valid, 1'b0);
    chk("a_ackld_addr", a_addr, 16'hFFFF);
    qa.push_back('{32'hC0DE_FFFF, 16'hFFFF, 16'h0000});
    a_fetch_req = 1; stp(); a_fetch_req = 0; stp();
    chk("a_wrap_addr", a_addr, 16'h0);
    qa.push_back('{32'h2000_0004, 16'h0000, 16'h0001});
    a_ack = 1; a_fetch_req = 1; stp(); a_ack = 0; a_fetch_req = 0; stp();
    chk("a_wrap_next_valid", a_valid, 1'b1);

    // A: pc_load in VALID without ack keeps IR valid
    a_pc_load = 1; a_plv = 16'h0010; stp(); a_pc_load = 0;
    chk("a_vld_ld_valid", a_valid, 1'b1);
    chk("a_vld_ld_addr", a_addr, 16'h0010);
    chk("a_vld_ld_ir", a_instr, 32'h2000_0004);
    a_ack = 1; stp(); a_ack = 0;

`ifdef FETCH_HALT_DETECT_EN
    a_pc_load = 1; a_plv = 16'h0002; stp(); a_pc_load = 0;
    qa.push_back('{32'hFFFF_FFFF, 16'h0002, 16'h0003});
    a_fetch_req = 1; stp(); a_fetch_req = 0; stp();
    chk("a_halted_set", a_halted, 1'b1);
    chk("a_halt_addr_hold", a_addr, 16'h0002);
    a_ack = 1; stp(); a_ack = 0;
    a_fetch_req = 1; stp(); a_fetch_req = 0;
    chk("a_halt_ignore", a_busy, 1'b0);
    a_pc_load = 1; a_plv = 16'h0000; stp(); a_pc_load = 0;
    chk("a_halted_clr", a_halted, 1'b0);
`endif

    // A: async reset during WAIT
    a_fetch_req = 1; stp(); a_fetch_req = 0;
    chk("a_prerst_busy", a_busy, 1'b1);
    #3 a_rst_n = 0;
    #1;
    chk("a_arst_busy", a_busy, 1'b0);
    chk("a_arst_addr", a_addr, 16'h0);
    chk("a_arst_valid", a_valid, 1'b0);
    chk("a_arst_instr", a_instr, 32'h0);
    stp(); a_rst_n = 1;

    // B: latency 3
    qb.push_back('{32'h2000_0004, 16'h0000, 16'h0001});
    b_fetch_req = 1; stp(); b_fetch_req = 0;
    for (int i = 0; i < 3; i++) begin
      chk("b_lat_busy", b_busy, 1'b1);
      chk("b_lat_addr", b_addr, 16'h0);
      chk("b_lat_valid", b_valid, 1'b0);
      stp();
    end
    chk("b_lat_valid_up", b_valid, 1'b1);
    chk("b_lat_busy_down", b_busy, 1'b0);
    chk("b_lat_addr_inc", b_addr, 16'h1);

    // B: ack + pc_load + fetch_req -> redirect wins, IDLE
    b_ack = 1; b_pc_load = 1; b_plv = 16'h0020; b_fetch_req = 1; stp();
    b_ack = 0; b_pc_load = 0; b_fetch_req = 0;
    chk("b_all3_busy", b_busy, 1'b0);
    chk("b_all3_valid", b_valid, 1'b0);
    chk("b_all3_addr", b_addr, 16'h0020);

    // B: pc_load beats fetch_req in IDLE; held fetch_req then starts
    qb.push_back('{32'hC0DE_0030, 16'h0030, 16'h0031});
    b_pc_load = 1; b_plv = 16'h0030; b_fetch_req = 1; stp(); b_pc_load = 0;
    chk("b_both_busy", b_busy, 1'b0);
    chk("b_both_addr", b_addr, 16'h0030);
    stp(); b_fetch_req = 0;
    chk("b_held_busy", b_busy, 1'b1);
    repeat (3) stp();
    chk("b_held_valid", b_valid, 1'b1);
    b_ack = 1; stp(); b_ack = 0;
    stp();

    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
